// File: rtl/ctrl_pipe.sv
// Control pipeline: carries the ID-stage control bundle through EX, MEM and WB,
// resolves destination registers and inserts bubbles on load-use stalls or flushes.
module ctrl_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [7:0]       ID_EX_i,
  input  logic [4:0]       ID_rs_i,
  input  logic [4:0]       ID_rt_i,
  input  logic [4:0]       ID_rd_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             EX_ALUSrc_o,
  output logic [1:0]       EX_ALUOp_o,
  output logic             EX_RegDst_o,
  output logic [4:0]       EX_rs_o,
  output logic [4:0]       EX_rt_o,
  output logic             MEM_MemRead_o,
  output logic             MEM_MemWrite_o,
  output logic             MEM_RegWrite_o,
  output logic [4:0]       MEM_RegAddr_o,
  output logic             WB_RegWrite_o,
  output logic             WB_MemtoReg_o,
  output logic [4:0]       WB_RegAddr_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic [7:0]       ex_ctrl_reg;
  logic [4:0]       ex_rs_reg, ex_rt_reg, ex_rd_reg;
  logic             mem_regwrite_reg, mem_memtoreg_reg, mem_memread_reg, mem_memwrite_reg;
  logic [4:0]       mem_dst_reg;
  logic             wb_regwrite_reg, wb_memtoreg_reg;
  logic [4:0]       wb_dst_reg;
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;

  logic             load_use;
  logic             bubble;
  logic [4:0]       mem_dst_next;

  always_comb begin
    // Conservative: any ID source field matching the load target stalls.
    load_use       = ex_ctrl_reg[5] & (ex_rt_reg != 5'd0) &
                     ((ex_rt_reg == ID_rs_i) | (ex_rt_reg == ID_rt_i));
    bubble         = load_use | flush_i;
    mem_dst_next   = ex_ctrl_reg[0] ? ex_rd_reg : ex_rt_reg;
    stall_cnt_next = stall_cnt_reg;
    if (load_use && (stall_cnt_reg != {CNT_W{1'b1}}))
      stall_cnt_next = stall_cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_ctrl_reg <= 8'd0;
      ex_rs_reg   <= 5'd0;
      ex_rt_reg   <= 5'd0;
      ex_rd_reg   <= 5'd0;
    end else if (bubble) begin
      ex_ctrl_reg <= 8'd0;
      ex_rs_reg   <= 5'd0;
      ex_rt_reg   <= 5'd0;
      ex_rd_reg   <= 5'd0;
    end else begin
      ex_ctrl_reg <= ID_EX_i;
      ex_rs_reg   <= ID_rs_i;
      ex_rt_reg   <= ID_rt_i;
      ex_rd_reg   <= ID_rd_i;
    end
  end

  // MEM and WB never stall, so bubbles drain on their own.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_regwrite_reg <= 1'b0;
      mem_memtoreg_reg <= 1'b0;
      mem_memread_reg  <= 1'b0;
      mem_memwrite_reg <= 1'b0;
      mem_dst_reg      <= 5'd0;
      wb_regwrite_reg  <= 1'b0;
      wb_memtoreg_reg  <= 1'b0;
      wb_dst_reg       <= 5'd0;
      stall_cnt_reg    <= '0;
    end else begin
      mem_regwrite_reg <= ex_ctrl_reg[7] & (mem_dst_next != 5'd0);
      mem_memtoreg_reg <= ex_ctrl_reg[6];
      mem_memread_reg  <= ex_ctrl_reg[5];
      mem_memwrite_reg <= ex_ctrl_reg[4];
      mem_dst_reg      <= mem_dst_next;
      wb_regwrite_reg  <= mem_regwrite_reg;
      wb_memtoreg_reg  <= mem_memtoreg_reg;
      wb_dst_reg       <= mem_dst_reg;
      stall_cnt_reg    <= stall_cnt_next;
    end
  end

  assign stall_o        = load_use;
  assign EX_ALUSrc_o    = ex_ctrl_reg[3];
  assign EX_ALUOp_o     = ex_ctrl_reg[2:1];
  assign EX_RegDst_o    = ex_ctrl_reg[0];
  assign EX_rs_o        = ex_rs_reg;
  assign EX_rt_o        = ex_rt_reg;
  assign MEM_MemRead_o  = mem_memread_reg;
  assign MEM_MemWrite_o = mem_memwrite_reg;
  assign MEM_RegWrite_o = mem_regwrite_reg;
  assign MEM_RegAddr_o  = mem_dst_reg;
  assign WB_RegWrite_o  = wb_regwrite_reg;
  assign WB_MemtoReg_o  = wb_memtoreg_reg;
  assign WB_RegAddr_o   = wb_dst_reg;
  assign stall_cnt_o    = stall_cnt_reg;

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Consumes the 8-bit ID-stage control bundle and carries it through the EX, MEM and WB pipeline stages.
- Splits the bundle into per-stage control outputs and resolves each instruction's destination register.
- Detects load-use hazards and inserts bubbles, either on a load-use stall or on an external flush.
- Sits between the ID-stage decoder and the EX/MEM/WB datapath. Also feeds the forwarding unit and the PC/IF_ID write-enable logic.

Parameters:
- CNT_W, 16, width of the saturating stall-event counter.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- ID_EX_i  in  8  control bundle from the ID stage: [7] RegWrite, [6] MemtoReg, [5] MemRead, [4] MemWrite, [3] ALUSrc, [2:1] ALUOp, [0] RegDst.
- ID_rs_i  in  5  rs field of the instruction in ID.
- ID_rt_i  in  5  rt field of the instruction in ID.
- ID_rd_i  in  5  rd field of the instruction in ID.
- flush_i  in  1  kill the instruction currently in ID (branch taken).
- stall_o  out  1  load-use stall; holds PC and IF_ID this cycle.
- EX_ALUSrc_o  out  1  ALUSrc for the EX stage.
- EX_ALUOp_o  out  2  ALUOp for the EX stage.
- EX_RegDst_o  out  1  RegDst for the EX stage.
- EX_rs_o  out  5  rs of the instruction in EX, for forwarding.
- EX_rt_o  out  5  rt of the instruction in EX, for forwarding.
- MEM_MemRead_o  out  1  MemRead for the MEM stage.
- MEM_MemWrite_o  out  1  MemWrite for the MEM stage.
- MEM_RegWrite_o  out  1  RegWrite of the instruction in MEM, for forwarding.
- MEM_RegAddr_o  out  5  destination register of the instruction in MEM.
- WB_RegWrite_o  out  1  register-file write enable.
- WB_MemtoReg_o  out  1  WB source select.
- WB_RegAddr_o  out  5  register-file write address.
- stall_cnt_o  out  CNT_W  number of cycles with stall_o=1; saturates at all-ones.

Behaviour:
- Reset (rst_i=0, asynchronous): every stage register, every output and stall_cnt_o go to 0. The pipeline then holds three bubbles.
- Stage registers: EX holds ctrl[7:0], rs, rt, rd; MEM holds RegWrite, MemtoReg, MemRead, MemWrite, dst[4:0]; WB holds RegWrite, MemtoReg, dst[4:0].
- All *_o outputs are driven directly from stage registers, except stall_o, which is combinational.
- Latency: a bundle presented on ID_EX_i at edge N is visible on EX_* after edge N, on MEM_* after edge N+1, and on WB_* after edge N+2.
- stall_o = EX.ctrl[5] & (EX.rt != 0) & ((EX.rt == ID_rs_i) | (EX.rt == ID_rt_i)).
- stall_o is asserted regardless of whether the ID instruction actually reads rt, which is conservative.
- EX load: if stall_o or flush_i, EX.ctrl <= 0 (bubble) and EX rs/rt/rd <= 0. Otherwise EX takes ID_EX_i, ID_rs_i, ID_rt_i and ID_rd_i.
- When stall_o and flush_i are both high, a bubble is inserted exactly once per cycle. No double-counting effect on later stages.
- Destination resolution at the EX->MEM transfer: dst = EX.ctrl[0] ? EX.rd : EX.rt.
- MEM.RegWrite <= EX.ctrl[7] & (dst != 0). A write to $0 is never propagated.
- The remaining MEM bits copy EX.ctrl[6], [5] and [4].
- MEM and WB always advance every cycle; they are never stalled, so bubbles drain naturally.
- WB <= {MEM.RegWrite, MEM.MemtoReg, MEM.dst} every cycle.
- stall_cnt increments on each clock edge where stall_o=1 and holds once it reaches 2^CNT_W-1.
- flush_i alone does not count as a stall cycle.
- A stall lasts exactly one cycle for a single load. Because the bubble clears EX.ctrl[5], stall_o drops the next cycle without any external action.
- Reset asserted mid-operation discards all in-flight control immediately. No write enable may be seen on the first edge after reset release unless a real bundle has entered EX.
- An all-zero ID_EX_i (unknown opcode) is a legal bubble and passes through inert.

Test Plan:
- Reset, then hold ID_EX_i=0 for 5 cycles -> all outputs 0, stall_cnt_o=0.
- R-type: ID_EX_i=8'h85, rs=1, rt=2, rd=3 -> EX_ALUOp_o=2'b10 and EX_RegDst_o=1 after 1 edge; MEM_RegAddr_o=3 after 2 edges; WB_RegWrite_o=1 and WB_RegAddr_o=3 after 3 edges.
- Load-use: lw (8'hE8, rt=5), then add with rs=5 -> stall_o=1 for exactly 1 cycle and a bubble enters EX. The add reaches WB one cycle later than unstalled; stall_cnt_o=1.
- lw with rt=0 followed by a reader of $0 -> stall_o never asserts. R-type with rd=0 -> MEM_RegWrite_o=0 and WB_RegWrite_o=0.
- sw 8'h18 with flush_i=1 in the same cycle -> EX bundle is 0, MEM_MemWrite_o never asserts. A back-to-back sw without flush -> MEM_MemWrite_o=1 two edges later.
- Drop rst_i mid-stream with a lw in MEM and an R-type in EX -> all outputs 0 asynchronously, before the next edge. With CNT_W=2 and 5 forced stalls, stall_cnt_o saturates at 3.
